// File: rtl/temp_moving_average.sv
// Sliding-window moving average over 2^LOG2_N unsigned samples, running sum plus circular buffer.
// Optional macro AVG_PRIME_EN: the first sample after reset fills the whole window.
module temp_moving_average #(
  parameter int DATA_W = 16,
  parameter int LOG2_N = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_valid,
  output logic [DATA_W-1:0] temp_average,
  output logic              avg_valid,
  output logic              window_full
);
  localparam int N     = 1 << LOG2_N;
  localparam int SUM_W = DATA_W + LOG2_N;

  typedef enum logic {FILL, RUN} state_t;
  state_t state, state_next;

  logic [DATA_W-1:0] sample_buf [N];
  logic [SUM_W-1:0]  sum, sum_next;
  logic [LOG2_N-1:0] wr_ptr, count;
  logic              prime;

  // The evicted slot is read before it is overwritten on the same edge.
  assign sum_next = sum + SUM_W'(sample_in) - SUM_W'(sample_buf[wr_ptr]);

`ifdef AVG_PRIME_EN
  assign prime = sample_valid && (state == FILL) && (count == '0);
`else
  assign prime = 1'b0;
`endif

  always_comb begin
    state_next = state;
    if (sample_valid && (state == FILL) && (prime || (count == LOG2_N'(N - 1))))
      state_next = RUN;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= FILL;
    else       state <= state_next;
  end

  assign window_full = (state == RUN);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) sample_buf[i] <= '0;
      sum          <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      temp_average <= '0;
      avg_valid    <= 1'b0;
    end else begin
      avg_valid <= sample_valid;
      if (prime) begin
        for (int i = 0; i < N; i++) sample_buf[i] <= sample_in;
        sum          <= {sample_in, {LOG2_N{1'b0}}};
        wr_ptr       <= LOG2_N'(1);
        temp_average <= sample_in;
      end else if (sample_valid) begin
        sample_buf[wr_ptr] <= sample_in;
        sum                <= sum_next;
        wr_ptr             <= wr_ptr + LOG2_N'(1);
        temp_average       <= sum_next[SUM_W-1:LOG2_N];
        if ((state == FILL) && (state_next == FILL))
          count <= count + LOG2_N'(1);
      end
    end
  end
endmodule

// File: tb/tb_temp_moving_average.sv
// Directed self-checking bench for temp_moving_average (window of 4, or 8 with AVG_PRIME_EN).
module tb_temp_moving_average;
`ifdef AVG_PRIME_EN
  localparam int TB_LOG2_N = 3;
`else
  localparam int TB_LOG2_N = 2;
`endif

  logic        clk;
  logic        reset;
  logic [15:0] sample_in;
  logic        sample_valid;
  logic [15:0] temp_average;
  logic        avg_valid;
  logic        window_full;

  int checks   = 0;
  int failures = 0;

  temp_moving_average #(.DATA_W(16), .LOG2_N(TB_LOG2_N)) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .temp_average (temp_average),
    .avg_valid    (avg_valid),
    .window_full  (window_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs on the falling edge; return 1 time unit after the rising edge.
  task automatic applyStimulus(input logic rst, input logic valid, input logic [15:0] data);
    @(negedge clk);
    reset        = rst;
    sample_valid = valid;
    sample_in    = data;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Feed one sample and check the average, valid pulse and window_full that follow it.
  task automatic sampleAndCheck(input string tag, input logic [15:0] data,
                                input logic [15:0] exp_avg, input logic exp_full);
    applyStimulus(1'b0, 1'b1, data);
    checkOutput({tag, "_avg"}, 32'(temp_average), 32'(exp_avg));
    checkOutput({tag, "_vld"}, 32'(avg_valid), 32'd1);
    checkOutput({tag, "_full"}, 32'(window_full), 32'(exp_full));
  endtask

  task automatic resetAndCheck(input string tag, input logic valid, input logic [15:0] data);
    applyStimulus(1'b1, valid, data);
    checkOutput({tag, "_avg"}, 32'(temp_average), 32'd0);
    checkOutput({tag, "_vld"}, 32'(avg_valid), 32'd0);
    checkOutput({tag, "_full"}, 32'(window_full), 32'd0);
  endtask

  initial begin
    reset        = 1'b1;
    sample_valid = 1'b0;
    sample_in    = '0;
    resetAndCheck("rst0", 1'b0, 16'd0);

`ifdef AVG_PRIME_EN
    sampleAndCheck("prime640", 16'd640, 16'd640, 1'b1);
    sampleAndCheck("prime1280", 16'd1280, 16'd720, 1'b1);
    sampleAndCheck("prime1280b", 16'd1280, 16'd800, 1'b1);
    applyStimulus(1'b0, 1'b0, 16'd0);
    checkOutput("prime_idle_vld", 32'(avg_valid), 32'd0);
    checkOutput("prime_idle_avg", 32'(temp_average), 32'd800);
`else
    // Ramp-up from an empty window, then wrap and eviction.
    sampleAndCheck("s100", 16'd100, 16'd25, 1'b0);
    sampleAndCheck("s200", 16'd200, 16'd75, 1'b0);
    sampleAndCheck("s300", 16'd300, 16'd150, 1'b0);
    sampleAndCheck("s400", 16'd400, 16'd250, 1'b1);
    sampleAndCheck("s500", 16'd500, 16'd350, 1'b1);
    sampleAndCheck("s100w", 16'd100, 16'd325, 1'b1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 16'd7777);
      checkOutput("hold325_vld", 32'(avg_valid), 32'd0);
      checkOutput("hold325_avg", 32'(temp_average), 32'd325);
    end
    checkOutput("hold325_full", 32'(window_full), 32'd1);

    // Full-scale samples must not overflow the sum.
    resetAndCheck("rst1", 1'b0, 16'd0);
    sampleAndCheck("ff1", 16'hFFFF, 16'h3FFF, 1'b0);
    sampleAndCheck("ff2", 16'hFFFF, 16'h7FFF, 1'b0);
    sampleAndCheck("ff3", 16'hFFFF, 16'hBFFF, 1'b0);
    sampleAndCheck("ff4", 16'hFFFF, 16'hFFFF, 1'b1);
    sampleAndCheck("z1", 16'h0000, 16'hBFFF, 1'b1);
    sampleAndCheck("z2", 16'h0000, 16'h7FFF, 1'b1);
    sampleAndCheck("z3", 16'h0000, 16'h3FFF, 1'b1);
    sampleAndCheck("z4", 16'h0000, 16'h0000, 1'b1);

    // Truncation and idle hold.
    resetAndCheck("rst2", 1'b0, 16'd0);
    sampleAndCheck("t1", 16'd1, 16'd0, 1'b0);
    sampleAndCheck("t2", 16'd2, 16'd0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b0, 16'd4000);
      checkOutput("idle_vld", 32'(avg_valid), 32'd0);
      checkOutput("idle_avg", 32'(temp_average), 32'd0);
    end
    sampleAndCheck("t3", 16'd5, 16'd2, 1'b0);

    // Mid-stream reset, then reset colliding with a valid sample.
    resetAndCheck("rst3", 1'b0, 16'd0);
    sampleAndCheck("k1", 16'd1000, 16'd250, 1'b0);
    sampleAndCheck("k2", 16'd1000, 16'd500, 1'b0);
    sampleAndCheck("k3", 16'd1000, 16'd750, 1'b0);
    resetAndCheck("midrst", 1'b0, 16'd0);
    sampleAndCheck("after800", 16'd800, 16'd200, 1'b0);
    resetAndCheck("rstvalid", 1'b1, 16'd999);
    sampleAndCheck("after400", 16'd400, 16'd100, 1'b0);
    sampleAndCheck("next400", 16'd400, 16'd200, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
